// File: rtl/rr_resource_arbiter.sv
// -----------------------------------------------------------------------------
// rr_resource_arbiter
//
// Round-robin arbiter that hands one shared resource (bus, datapath unit, ...)
// to N_REQ requesters. Ownership follows a req/gnt/done handshake. Between two
// owners there is always exactly one dead cycle with gnt all-zero.
//
// Optional feature (compile-time macro): ARB_TIMEOUT_EN
//   defined   : a hold counter revokes a grant after MAX_HOLD cycles without
//               a release. A one-cycle timeout pulse flags the revocation.
//   undefined : no counter exists, timeout is tied low, and a grant lasts as
//               long as its owner keeps requesting.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   ID_W     width of gnt_id, must equal clog2(N_REQ)
//   MAX_HOLD grant-cycle limit per owner, only used with ARB_TIMEOUT_EN (2..15)
//
// Ports
//   clk      in   1      clock, every state update happens on posedge
//   reset_L  in   1      asynchronous active-low reset
//   req      in   N_REQ  req[i]=1 : requester i wants the resource
//   done     in   N_REQ  release strobe, only done[gnt_id] counts while granted
//   gnt      out  N_REQ  registered one-hot grant, zero when nobody owns
//   gnt_id   out  ID_W   index of the current owner, or of the last owner
//   busy     out  1      registered copy of |gnt
//   timeout  out  1      one-cycle pulse when the hold limit revokes a grant
// -----------------------------------------------------------------------------
module rr_resource_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Requester count at the width of the rotation sum. This keeps the modulo
  // reduction free of width mismatches.
  localparam logic [ID_W:0]    N_REQ_X = (ID_W + 1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_id, last_id_d;
  logic [N_REQ-1:0] gnt_d;
  logic [ID_W-1:0]  gnt_id_d;
  logic             busy_d;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;

`ifdef ARB_TIMEOUT_EN
  localparam int               HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic              timeout_d;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick. The search starts at last_id+1 and wraps modulo N_REQ.
  // The loop runs from the farthest offset down to the nearest one, so the
  // last match is the nearest pending requester.
  // ---------------------------------------------------------------------------
  always_comb begin : arbitrate
    logic [ID_W:0] cand;
    // NOTE: every signal driven here gets a value before any branch. A path
    // that left one unassigned would infer a latch.
    cand       = '0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, last_id} + (ID_W + 1)'(k);
      if (cand >= N_REQ_X) begin
        cand = cand - N_REQ_X;
      end
      if (req[cand[ID_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = cand[ID_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    logic release_hit;
    release_hit = done[gnt_id] | ~req[gnt_id];

    state_d   = state_q;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    busy_d    = busy;
    last_id_d = last_id;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt;
    timeout_d  = 1'b0;
`endif

    unique case (state_q)
      // The edge that closes the dead cycle arbitrates exactly as IDLE does.
      // This keeps the gap at one cycle while other requesters are waiting.
      // last_id already holds the previous owner, so that owner is searched
      // last and wins only when nobody else is requesting.
      ST_IDLE, ST_GAP: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_valid) begin
          state_d  = ST_GRANT;
          gnt_d    = ONE_HOT << pick_id;
          gnt_id_d = pick_id;
          busy_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Only the owner's req/done bits are looked at. A release takes
      // priority over the hold limit when both happen on the same edge.
      ST_GRANT: begin
        if (release_hit) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          busy_d    = 1'b0;
          last_id_d = gnt_id;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt == HOLD_END) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          busy_d    = 1'b0;
          last_id_d = gnt_id;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. After reset, requester 0 has top priority,
  // because last_id starts at N_REQ-1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      last_id <= ID_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register take its new
      // value from values computed before the edge, with no evaluation-order
      // race between flops.
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      busy    <= busy_d;
      last_id <= last_id_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_cnt_d;
      timeout  <= timeout_d;
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_resource_arbiter
//
// Self-checking bench for rr_resource_arbiter with N_REQ=4 and MAX_HOLD=8.
//
// A reference model tracks the owner as an integer (-1 when nobody owns). On
// every cycle the model's view of gnt, gnt_id, busy and timeout is compared
// against the DUT. Directed scenarios add hand-computed literal expectations
// on top of the model: reset, single grant, fairness rotation, wrap and skip,
// ignored non-owner inputs, and the hold limit. The hold-limit scenario
// follows whether ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_rr_resource_arbiter;

  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 8;

  logic             clk;
  logic             reset_L;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_resource_arbiter #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Its state is the owner index, the last owner, the number
  // of grant edges the current owner has survived, and the timeout pulse.
  // Whenever nobody owns, each edge makes a fresh round-robin search, because
  // a released owner always leaves exactly one empty cycle.
  // ---------------------------------------------------------------------------
  int m_owner = -1;
  int m_last  = N_REQ - 1;
  int m_id    = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_L);
      if (!reset_L) begin
        m_owner = -1;
        m_last  = N_REQ - 1;
        m_id    = 0;
        m_held  = 0;
        m_to    = 1'b0;
      end else begin
        m_to = 1'b0;
        if (m_owner < 0) begin
          for (int k = 1; k <= N_REQ; k++) begin
            int c;
            c = (m_last + k) % N_REQ;
            if (m_owner < 0 && req[c] === 1'b1) begin
              m_owner = c;
              m_id    = c;
              m_held  = 0;
            end
          end
        end else if (done[m_owner] === 1'b1 || req[m_owner] !== 1'b1) begin
          m_last  = m_owner;
          m_owner = -1;
`ifdef ARB_TIMEOUT_EN
        end else if (m_held + 1 >= MAX_HOLD) begin
          m_last  = m_owner;
          m_owner = -1;
          m_to    = 1'b1;
`endif
        end else begin
          m_held++;
        end
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("model_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("model_gnt_id", 32'(gnt_id), 32'(m_id));
      check("model_busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      check("model_timeout", 32'(timeout), 32'(m_to));
    end
  end

  // Apply req and done from the current falling edge, then advance past one
  // rising edge and stop at the next falling edge.
  task automatic cyc(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [N_REQ-1:0] g,
                            input logic [ID_W-1:0] id, input logic b, input logic t);
    check({name, "_gnt"}, 32'(gnt), 32'(g));
    check({name, "_id"}, 32'(gnt_id), 32'(id));
    check({name, "_busy"}, 32'(busy), 32'(b));
    check({name, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    logic [N_REQ-1:0] fair_gnt [5];
    logic [ID_W-1:0]  fair_id  [5];
    fair_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    req     = '0;
    done    = '0;
    reset_L = 1'b1;
    #1 reset_L = 1'b0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2. Release with done at edge 4, then stay idle.
    cyc(4'b0100, 4'b0000);
    expect_out("single_e1", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0000);
    cyc(4'b0100, 4'b0000);
    expect_out("single_e3", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0100);
    expect_out("single_e4", 4'b0000, 2'd2, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0000);
    expect_out("single_e5", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Last owner is 2, so req=1111 grants 3. Assert reset mid-grant,
    // away from any clock edge.
    cyc(4'b1111, 4'b0000);
    expect_out("pre_reset", 4'b1000, 2'd3, 1'b1, 1'b0);
    #3 reset_L = 1'b0;
    #1 expect_out("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;

    // Fairness: req held at 1111, each owner pulses done two cycles after
    // its grant. Owners follow 0,1,2,3,0 with one empty cycle between them.
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b0000);
      expect_out($sformatf("fair_grant%0d", i), fair_gnt[i], fair_id[i], 1'b1, 1'b0);
      cyc(4'b1111, 4'b0000);
      cyc(4'b1111, fair_gnt[i]);
      expect_out($sformatf("fair_gap%0d", i), 4'b0000, fair_id[i], 1'b0, 1'b0);
    end

    // Wrap and skip. Make 1 the last owner; req=1001 then grants 3, and the
    // next arbitration with the same req wraps round to 0.
    cyc(4'b0010, 4'b0000);
    expect_out("wrap_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000);
    cyc(4'b1001, 4'b0000);
    expect_out("wrap_skip3", 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000);
    cyc(4'b1001, 4'b0000);
    expect_out("wrap_to0", 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);

    // Non-owner done and req bits have no effect. Dropping the owner's req
    // releases the grant.
    cyc(4'b0100, 4'b0000);
    expect_out("ign_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(4'b1111, 4'b1011);
    expect_out("ign_done", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(4'b1011, 4'b0000);
    expect_out("ign_release", 4'b0000, 2'd2, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);

    // Hold limit with req=0110 held and no done. The last owner is 2, so
    // requester 1 is granted first.
    cyc(4'b0110, 4'b0000);
    expect_out("hold_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < MAX_HOLD; c++) begin
      cyc(4'b0110, 4'b0000);
      expect_out($sformatf("hold_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    cyc(4'b0110, 4'b0000);
    expect_out("hold_revoke", 4'b0000, 2'd1, 1'b0, 1'b1);
    cyc(4'b0110, 4'b0000);
    expect_out("hold_next", 4'b0100, 2'd2, 1'b1, 1'b0);
    // When done arrives on the same edge the limit expires, done wins.
    for (int c = 1; c < MAX_HOLD; c++) begin
      cyc(4'b0110, 4'b0000);
    end
    cyc(4'b0110, 4'b0100);
    expect_out("hold_done_wins", 4'b0000, 2'd2, 1'b0, 1'b0);
    cyc(4'b0110, 4'b0000);
    expect_out("hold_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    for (int c = 1; c <= 100; c++) begin
      cyc(4'b0110, 4'b0000);
      check("nohold_gnt", 32'(gnt), 32'(4'b0010));
      check("nohold_timeout", 32'(timeout), 32'd0);
    end
`endif
    cyc(4'b0000, 4'b0000);
    expect_out("final_release", 4'b0000, gnt_id, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
